// File: rtl/mips16_pkg.sv
// Shared constants and state encoding for the MIPS16 image loader.
// The stream carries the instruction image, the data image, two in_val words and a checksum word.
package mips16_pkg;

    localparam int WIDTH      = 16;
    localparam int DEPTH      = 24;
    localparam int STREAM_LEN = 2 * DEPTH + 3;

    typedef enum logic [2:0] {
        IDLE,
        LD_INSTR,
        LD_DATA,
        LD_VAL,
        LD_SUM,
        RUN,
        ERROR
    } state_e;

endpackage

// File: rtl/mips16_if.sv
// Valid/ready word stream from the image source into the loader.
interface mips16_if #(
    parameter int WIDTH = mips16_pkg::WIDTH
);

    logic             s_valid;
    logic [WIDTH-1:0] s_data;
    logic             s_ready;

    modport master (output s_valid, output s_data, input s_ready);
    modport slave  (input s_valid, input s_data, output s_ready);

endinterface

// File: rtl/mips16_ld_ctr.sv
// Word index within the current stream region.
// It returns to zero on the word that completes the region, so it never wraps inside a region.
module mips16_ld_ctr #(
    parameter int CW = 5
) (
    input  logic          clk,
    input  logic          rst,
    input  logic          clear,
    input  logic          inc,
    input  logic [CW-1:0] limit,
    output logic [CW-1:0] idx,
    output logic          done
);

    logic [CW-1:0] idx_q, idx_d;

    assign done = inc && (idx_q == limit - CW'(1));
    assign idx  = idx_q;

    always_comb begin
        idx_d = idx_q;
        if (clear) begin
            idx_d = '0;
        end else if (inc) begin
            idx_d = done ? '0 : idx_q + CW'(1);
        end
    end

    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            idx_q <= '0;
        end else begin
            idx_q <= idx_d;
        end
    end

endmodule

// File: rtl/mips16_image_loader.sv
// Loads instruction/data images and an initial register value from a word stream.
// The CPU core is released only after the checksum word matches the running sum.
module mips16_image_loader #(
    parameter int WIDTH = mips16_pkg::WIDTH,
    parameter int DEPTH = mips16_pkg::DEPTH
) (
    input  logic                   clk,
    input  logic                   rst,
    input  logic                   start,
    mips16_if.slave                s_if,
    output logic [WIDTH*DEPTH-1:0] in_instr,
    output logic [WIDTH*DEPTH-1:0] in_data,
    output logic [2*WIDTH-1:0]     in_val,
    output logic                   cpu_rst,
    output logic                   busy,
    output logic                   err,
    output logic [15:0]            run_cnt
);

    import mips16_pkg::*;

    state_e                 state_q, state_d;
    logic [WIDTH*DEPTH-1:0] in_instr_q, in_instr_d;
    logic [WIDTH*DEPTH-1:0] in_data_q, in_data_d;
    logic [2*WIDTH-1:0]     in_val_q, in_val_d;
    logic [15:0]            sum_q, sum_d;
    logic [15:0]            run_cnt_q, run_cnt_d;
    logic                   err_q, err_d;
    logic                   loading;
    logic                   accept;
    logic                   region_done;
    logic [4:0]             idx;
    logic [4:0]             limit;
    logic [15:0]            word16;

    assign loading = state_q inside {LD_INSTR, LD_DATA, LD_VAL, LD_SUM};
    assign accept  = loading && s_if.s_valid;
    assign word16  = 16'(s_if.s_data);

    always_comb begin
        limit = 5'd1;
        unique case (state_q)
            LD_INSTR, LD_DATA: limit = 5'(DEPTH);
            LD_VAL:            limit = 5'd2;
            default:           limit = 5'd1;
        endcase
    end

    // A start pulse restarts the index even if a word is offered in the same cycle.
    mips16_ld_ctr #(.CW(5)) u_ctr (
        .clk   (clk),
        .rst   (rst),
        .clear (start),
        .inc   (accept && !start),
        .limit (limit),
        .idx   (idx),
        .done  (region_done)
    );

    always_comb begin
        state_d    = state_q;
        in_instr_d = in_instr_q;
        in_data_d  = in_data_q;
        in_val_d   = in_val_q;
        sum_d      = sum_q;
        run_cnt_d  = run_cnt_q;
        err_d      = err_q;
        if (start) begin
            state_d   = LD_INSTR;
            sum_d     = '0;
            run_cnt_d = '0;
            err_d     = 1'b0;
        end else begin
            unique case (state_q)
                LD_INSTR: if (accept) begin
                    in_instr_d[(DEPTH-1-int'(idx))*WIDTH +: WIDTH] = s_if.s_data;
                    sum_d = sum_q + word16;
                    if (region_done) state_d = LD_DATA;
                end
                LD_DATA: if (accept) begin
                    in_data_d[(DEPTH-1-int'(idx))*WIDTH +: WIDTH] = s_if.s_data;
                    sum_d = sum_q + word16;
                    if (region_done) state_d = LD_VAL;
                end
                LD_VAL: if (accept) begin
                    in_val_d[(1-int'(idx))*WIDTH +: WIDTH] = s_if.s_data;
                    sum_d = sum_q + word16;
                    if (region_done) state_d = LD_SUM;
                end
                LD_SUM: if (accept) begin
                    if (word16 == sum_q) begin
                        state_d = RUN;
                    end else begin
                        state_d = ERROR;
                        err_d   = 1'b1;
                    end
                end
                RUN: if (run_cnt_q != 16'hFFFF) run_cnt_d = run_cnt_q + 16'd1;
                default: ;
            endcase
        end
    end

    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            state_q    <= IDLE;
            in_instr_q <= '0;
            in_data_q  <= '0;
            in_val_q   <= '0;
            sum_q      <= '0;
            run_cnt_q  <= '0;
            err_q      <= 1'b0;
        end else begin
            state_q    <= state_d;
            in_instr_q <= in_instr_d;
            in_data_q  <= in_data_d;
            in_val_q   <= in_val_d;
            sum_q      <= sum_d;
            run_cnt_q  <= run_cnt_d;
            err_q      <= err_d;
        end
    end

    assign s_if.s_ready = loading;
    assign busy         = loading;
    assign cpu_rst      = (state_q == RUN);
    assign err          = err_q;
    assign run_cnt      = run_cnt_q;
    assign in_instr     = in_instr_q;
    assign in_data      = in_data_q;
    assign in_val       = in_val_q;

endmodule

// File: tb/tb_mips16_image_loader.sv
// Directed sequence with random image contents, checked against a word-list model of the load.
module tb_mips16_image_loader;

    import mips16_pkg::*;

    localparam int W = WIDTH;
    localparam int D = DEPTH;

    logic           clk;
    logic           rst;
    logic           start;
    logic [W*D-1:0] in_instr;
    logic [W*D-1:0] in_data;
    logic [2*W-1:0] in_val;
    logic           cpu_rst;
    logic           busy;
    logic           err;
    logic [15:0]    run_cnt;

    int vectors;
    int miscompares;

    logic [15:0]    instr_w [D];
    logic [15:0]    data_w  [D];
    logic [15:0]    val_w   [2];
    logic [15:0]    stream  [$];
    logic [W*D-1:0] exp_instr;
    logic [W*D-1:0] exp_data;
    logic [2*W-1:0] exp_val;
    logic [15:0]    exp_sum;

    mips16_if #(.WIDTH(W)) bus ();

    mips16_image_loader #(.WIDTH(W), .DEPTH(D)) dut (
        .clk      (clk),
        .rst      (rst),
        .start    (start),
        .s_if     (bus),
        .in_instr (in_instr),
        .in_data  (in_data),
        .in_val   (in_val),
        .cpu_rst  (cpu_rst),
        .busy     (busy),
        .err      (err),
        .run_cnt  (run_cnt)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    task automatic check_output(input string tag, input logic [W*D-1:0] got, input logic [W*D-1:0] exp);
        vectors++;
        assert (got === exp) else begin
            miscompares++;
            $error("[TB] FAIL %s: observed %0h expected %0h", tag, got, exp);
        end
    endtask

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    task automatic pulse_start();
        start = 1'b1;
        tick();
        start = 1'b0;
    endtask

    // Images are the words in stream order with word 0 ending up most significant.
    task automatic build_model(input bit fixed_first);
        for (int i = 0; i < D; i++) begin
            instr_w[i] = 16'($urandom);
            data_w[i]  = 16'($urandom);
        end
        val_w[0] = 16'($urandom);
        val_w[1] = 16'($urandom);
        if (fixed_first) begin
            instr_w[0] = 16'h9903;
            data_w[0]  = 16'h0000;
            val_w[0]   = 16'h0000;
            val_w[1]   = 16'h0000;
        end
        exp_instr = '0;
        exp_data  = '0;
        exp_sum   = '0;
        for (int i = 0; i < D; i++) begin
            exp_instr = {exp_instr[W*D-W-1:0], instr_w[i]};
            exp_data  = {exp_data[W*D-W-1:0], data_w[i]};
            exp_sum   = exp_sum + instr_w[i] + data_w[i];
        end
        exp_val = {val_w[0], val_w[1]};
        exp_sum = exp_sum + val_w[0] + val_w[1];
    endtask

    task automatic apply_stimulus(input bit bad_sum, input bit toggle, input int nwords);
        stream = {};
        for (int i = 0; i < D; i++) stream.push_back(instr_w[i]);
        for (int i = 0; i < D; i++) stream.push_back(data_w[i]);
        stream.push_back(val_w[0]);
        stream.push_back(val_w[1]);
        stream.push_back(bad_sum ? exp_sum + 16'd1 : exp_sum);
        for (int i = 0; i < nwords; i++) begin
            check_output("s_ready_during_load", bus.s_ready, 1);
            check_output("cpu_rst_during_load", cpu_rst, 0);
            bus.s_valid = 1'b1;
            bus.s_data  = stream[i];
            tick();
            if (toggle && i < nwords - 1) begin
                bus.s_valid = 1'b0;
                bus.s_data  = 16'($urandom);
                tick();
            end
        end
        bus.s_valid = 1'b0;
    endtask

    task automatic check_images(input string tag);
        check_output({tag, "_instr"}, in_instr, exp_instr);
        check_output({tag, "_data"},  in_data,  exp_data);
        check_output({tag, "_val"},   in_val,   exp_val);
    endtask

    initial begin
        vectors     = 0;
        miscompares = 0;
        rst         = 1'b0;
        start       = 1'b0;
        bus.s_valid = 1'b0;
        bus.s_data  = '0;

        #2;
        check_output("rst_s_ready", bus.s_ready, 0);
        check_output("rst_busy",    busy,        0);
        check_output("rst_cpu_rst", cpu_rst,     0);
        check_output("rst_err",     err,         0);
        check_output("rst_run_cnt", run_cnt,     0);
        check_output("rst_instr",   in_instr,    0);
        check_output("rst_data",    in_data,     0);
        check_output("rst_val",     in_val,      0);
        tick();
        tick();
        rst = 1'b1;
        repeat (3) tick();
        check_output("idle_no_autoload_ready", bus.s_ready, 0);
        check_output("idle_no_autoload_busy",  busy,        0);

        $display("[TB] good load, back-to-back");
        build_model(1'b1);
        pulse_start();
        check_output("load_busy", busy, 1);
        apply_stimulus(1'b0, 1'b0, STREAM_LEN);
        check_output("good_cpu_rst_at_52", cpu_rst, 1);
        check_output("good_busy",          busy,    0);
        check_output("good_s_ready",       bus.s_ready, 0);
        check_output("good_err",           err,     0);
        check_output("good_word0",         in_instr[383:368], 16'h9903);
        check_output("good_run_cnt0",      run_cnt, 0);
        check_images("good");
        repeat (5) tick();
        check_output("run_cnt_5", run_cnt, 5);

        $display("[TB] checksum off by one");
        pulse_start();
        check_output("restart_cpu_rst", cpu_rst, 0);
        check_output("restart_run_cnt", run_cnt, 0);
        check_output("restart_busy",    busy,    1);
        apply_stimulus(1'b1, 1'b0, STREAM_LEN);
        check_output("bad_err",     err,     1);
        check_output("bad_cpu_rst", cpu_rst, 0);
        check_output("bad_run_cnt", run_cnt, 0);
        check_output("bad_busy",    busy,    0);
        repeat (3) tick();
        check_output("bad_err_held",     err,         1);
        check_output("bad_run_cnt_held", run_cnt,     0);
        check_output("bad_s_ready",      bus.s_ready, 0);
        check_output("bad_cpu_rst_held", cpu_rst,     0);

        $display("[TB] valid toggling every cycle");
        pulse_start();
        check_output("start_clears_err", err, 0);
        apply_stimulus(1'b0, 1'b1, STREAM_LEN);
        check_output("toggle_cpu_rst_at_102", cpu_rst, 1);
        check_output("toggle_err", err, 0);
        check_images("toggle");

        $display("[TB] restart after 30 words");
        build_model(1'b0);
        pulse_start();
        apply_stimulus(1'b0, 1'b0, 30);
        start       = 1'b1;
        bus.s_valid = 1'b1;
        bus.s_data  = 16'($urandom);
        tick();
        start       = 1'b0;
        bus.s_valid = 1'b0;
        check_output("mid_restart_ready",   bus.s_ready, 1);
        check_output("mid_restart_busy",    busy,        1);
        check_output("mid_restart_cpu_rst", cpu_rst,     0);
        apply_stimulus(1'b0, 1'b0, STREAM_LEN);
        check_output("reload_cpu_rst", cpu_rst, 1);
        check_output("reload_err",     err,     0);
        check_images("reload");

        $display("[TB] run counter saturation");
        repeat (65534) tick();
        check_output("run_cnt_fffe", run_cnt, 16'hFFFE);
        tick();
        check_output("run_cnt_ffff", run_cnt, 16'hFFFF);
        repeat (4465) tick();
        check_output("run_cnt_saturated", run_cnt, 16'hFFFF);
        check_output("run_cpu_rst_held",  cpu_rst, 1);

        $display("[TB] asynchronous reset during run");
        #3;
        rst = 1'b0;
        #1;
        check_output("async_cpu_rst", cpu_rst,  0);
        check_output("async_instr",   in_instr, 0);
        check_output("async_data",    in_data,  0);
        check_output("async_val",     in_val,   0);
        check_output("async_run_cnt", run_cnt,  0);
        #2;
        rst = 1'b1;
        tick();
        tick();
        check_output("post_reset_idle_ready",   bus.s_ready, 0);
        check_output("post_reset_idle_busy",    busy,        0);
        check_output("post_reset_idle_cpu_rst", cpu_rst,     0);

        $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
        $finish;
    end

endmodule
